read_line_collector: RTL and testbench

// - Sits between the PSL buffer-write/response interfaces and the parity engine. Tracks outstanding

---
 rtl/read_line_collector_pkg.sv | 18 +
 rtl/read_line_collector_if.sv | 47 ++++
 rtl/read_line_collector_slot.sv | 74 +++++++
 rtl/read_line_collector.sv | 109 ++++++++++
 tb/tb_read_line_collector.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/read_line_collector_pkg.sv
// Shared types and helpers for the read line collector: response codes,
// per-tag slot states and the odd-parity helper used on tags and data dwords.
package read_line_collector_pkg;

  localparam logic [7:0] RESP_DONE = 8'h00;

  typedef enum logic [1:0] {
    FREE,
    PENDING,
    READY
  } slot_state_t;

  // Zero-extending a narrower field does not change its parity, so one width serves all.
  function automatic logic odd_par(input logic [63:0] v);
    return ~^v;
  endfunction

endpackage

// File: rtl/read_line_collector_if.sv
// Bundles the command-issuer, PSL buffer-write/response and line-consumer signals.
// The slave modport is the collector's view; master is the surrounding logic.
interface read_line_collector_if;

  logic          alloc_valid;
  logic [7:0]    alloc_tag;

  logic          ha_bwvalid;
  logic [7:0]    ha_bwtag;
  logic          ha_bwtagpar;
  logic [5:0]    ha_bwad;
  logic [0:511]  ha_bwdata;
  logic [7:0]    ha_bwpar;

  logic          ha_rvalid;
  logic [7:0]    ha_rtag;
  logic          ha_rtagpar;
  logic [7:0]    ha_response;

  logic          line_valid;
  logic          line_ready;
  logic [7:0]    line_tag;
  logic [0:1023] line_data;
  logic          line_ok;

  logic          err_parity;
  logic          err_tag;

  modport slave (
    input  alloc_valid, alloc_tag,
    input  ha_bwvalid, ha_bwtag, ha_bwtagpar, ha_bwad, ha_bwdata, ha_bwpar,
    input  ha_rvalid, ha_rtag, ha_rtagpar, ha_response,
    input  line_ready,
    output line_valid, line_tag, line_data, line_ok,
    output err_parity, err_tag
  );

  modport master (
    output alloc_valid, alloc_tag,
    output ha_bwvalid, ha_bwtag, ha_bwtagpar, ha_bwad, ha_bwdata, ha_bwpar,
    output ha_rvalid, ha_rtag, ha_rtagpar, ha_response,
    output line_ready,
    input  line_valid, line_tag, line_data, line_ok,
    input  err_parity, err_tag
  );

endinterface

// File: rtl/read_line_collector_slot.sv
// One tag slot: lifecycle FSM, half-present flags, sticky parity error,
// response code and the 128-byte line storage.
module read_line_collector_slot
  import read_line_collector_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          alloc,
  input  logic          bw_we,
  input  logic          bw_half,
  input  logic [0:511]  bw_data,
  input  logic          bw_perr,
  input  logic          rsp,
  input  logic [7:0]    rsp_code,
  input  logic          release_slot,
  output slot_state_t   state,
  output logic [0:1023] data,
  output logic          ok
);

  slot_state_t   state_reg, state_next;
  logic          half0_reg, half1_reg, perr_reg;
  logic [7:0]    rcode_reg;
  logic [0:1023] data_reg;

  always_ff @(posedge clock) begin
    if (reset) state_reg <= FREE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FREE:    if (alloc)        state_next = PENDING;
      PENDING: if (rsp)          state_next = READY;
      READY:   if (release_slot) state_next = FREE;
      default:                   state_next = FREE;
    endcase
  end

  // The top only raises bw_we/rsp for a PENDING slot and alloc for a FREE one.
  always_ff @(posedge clock) begin
    if (reset) begin
      half0_reg <= 1'b0;
      half1_reg <= 1'b0;
      perr_reg  <= 1'b0;
      rcode_reg <= 8'h00;
    end else if (alloc) begin
      half0_reg <= 1'b0;
      half1_reg <= 1'b0;
      perr_reg  <= 1'b0;
      rcode_reg <= 8'h00;
    end else begin
      if (bw_we) begin
        if (bw_half) half1_reg <= 1'b1;
        else         half0_reg <= 1'b1;
        if (bw_perr) perr_reg <= 1'b1;
      end
      if (rsp) rcode_reg <= rsp_code;
    end
  end

  always_ff @(posedge clock) begin
    if (bw_we) begin
      if (bw_half) data_reg[512:1023] <= bw_data;
      else         data_reg[0:511]    <= bw_data;
    end
  end

  assign state = state_reg;
  assign data  = data_reg;
  assign ok    = (rcode_reg == RESP_DONE) && half0_reg && half1_reg && !perr_reg;

endmodule

// File: rtl/read_line_collector.sv
// Decodes allocs, buffer writes and responses onto per-tag slots, checks parity,
// and presents completed lines lowest-slot-first with a lock held until handshake.
module read_line_collector
  import read_line_collector_pkg::*;
#(
  parameter int NUM_SLOTS = 4
) (
  input logic           clock,
  input logic           reset,
  read_line_collector_if.slave bus
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  slot_state_t          slot_state [NUM_SLOTS];
  logic [0:1023]        slot_data  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_ok;
  logic [NUM_SLOTS-1:0] alloc_hit, bw_hit, rsp_hit, release_hit, ready_vec;

  logic                 bw_tagpar_ok, rsp_tagpar_ok;
  logic                 bw_gate, rsp_gate, bw_perr;
  logic [7:0]           dword_bad;

  logic                 sel_valid, handshake;
  logic [IDX_W-1:0]     sel_idx, lowest_idx;
  logic                 lock_reg;
  logic [IDX_W-1:0]     lock_idx_reg;
  logic                 err_parity_reg, err_tag_reg;

  assign bw_tagpar_ok  = bus.ha_bwtagpar == odd_par({56'd0, bus.ha_bwtag});
  assign rsp_tagpar_ok = bus.ha_rtagpar  == odd_par({56'd0, bus.ha_rtag});
  assign bw_gate       = bus.ha_bwvalid && bw_tagpar_ok && (bus.ha_bwad <= 6'd1);
  assign rsp_gate      = bus.ha_rvalid && rsp_tagpar_ok;

  for (genvar gi = 0; gi < 8; gi++) begin : g_dword
    assign dword_bad[gi] = bus.ha_bwpar[gi] != odd_par(bus.ha_bwdata[64*gi +: 64]);
  end
  assign bw_perr = |dword_bad;

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    assign alloc_hit[gi]   = bus.alloc_valid && (bus.alloc_tag == 8'(gi)) && (slot_state[gi] == FREE);
    assign bw_hit[gi]      = bw_gate  && (bus.ha_bwtag == 8'(gi)) && (slot_state[gi] == PENDING);
    assign rsp_hit[gi]     = rsp_gate && (bus.ha_rtag  == 8'(gi)) && (slot_state[gi] == PENDING);
    assign ready_vec[gi]   = slot_state[gi] == READY;
    assign release_hit[gi] = handshake && (sel_idx == IDX_W'(gi));

    read_line_collector_slot u_slot (
      .clock        (clock),
      .reset        (reset),
      .alloc        (alloc_hit[gi]),
      .bw_we        (bw_hit[gi]),
      .bw_half      (bus.ha_bwad[0]),
      .bw_data      (bus.ha_bwdata),
      .bw_perr      (bw_perr),
      .rsp          (rsp_hit[gi]),
      .rsp_code     (bus.ha_response),
      .release_slot (release_hit[gi]),
      .state        (slot_state[gi]),
      .data         (slot_data[gi]),
      .ok           (slot_ok[gi])
    );
  end

  always_comb begin
    lowest_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (ready_vec[i]) lowest_idx = IDX_W'(i);
    end
  end

  // A locked slot is always READY, so sel_valid covers both locked and fresh picks.
  assign sel_valid = |ready_vec;
  assign sel_idx   = lock_reg ? lock_idx_reg : lowest_idx;
  assign handshake = sel_valid && bus.line_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      lock_reg     <= 1'b0;
      lock_idx_reg <= '0;
    end else if (handshake) begin
      lock_reg     <= 1'b0;
    end else if (sel_valid) begin
      lock_reg     <= 1'b1;
      lock_idx_reg <= sel_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_parity_reg <= 1'b0;
      err_tag_reg    <= 1'b0;
    end else begin
      err_parity_reg <= (bus.ha_bwvalid && !bw_tagpar_ok) ||
                        (bus.ha_rvalid && !rsp_tagpar_ok) ||
                        ((|bw_hit) && bw_perr);
      err_tag_reg    <= (bus.alloc_valid && !(|alloc_hit)) ||
                        (bus.ha_bwvalid && bw_tagpar_ok && !(|bw_hit)) ||
                        (bus.ha_rvalid && rsp_tagpar_ok && !(|rsp_hit));
    end
  end

  assign bus.line_valid = sel_valid;
  assign bus.line_tag   = sel_valid ? 8'(sel_idx) : 8'd0;
  assign bus.line_data  = sel_valid ? slot_data[sel_idx] : '0;
  assign bus.line_ok    = sel_valid && slot_ok[sel_idx];
  assign bus.err_parity = err_parity_reg;
  assign bus.err_tag    = err_tag_reg;

endmodule

// File: tb/tb_read_line_collector.sv
// Self-checking bench: directed sequences, an error-vector table and random traffic,
// all scored against a per-tag transaction model.
module tb_read_line_collector;

  localparam int NS = 4;

  logic clock;
  logic reset;
  read_line_collector_if bus ();

  read_line_collector #(.NUM_SLOTS(NS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_mis = 0;

  // Model: 0 free, 1 pending, 2 ready
  int           m_state [NS];
  bit           m_h     [NS][2];
  bit           m_perr  [NS];
  logic [7:0]   m_rc    [NS];
  logic [0:511] m_d     [NS][2];
  bit           m_lock;
  int           m_lock_t;
  bit           e_tag, e_par;

  typedef struct {
    bit         av;
    logic [7:0] at;
    bit         bv;
    logic [7:0] bt;
    bit         btp_bad;
    logic [5:0] bad;
    bit         rv;
    logic [7:0] rt;
    bit         rtp_bad;
    bit         exp_tag;
    bit         exp_par;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      m_state[i] = 0;
      m_h[i][0]  = 0;
      m_h[i][1]  = 0;
      m_perr[i]  = 0;
      m_rc[i]    = 8'h00;
    end
    m_lock   = 0;
    m_lock_t = 0;
    e_tag    = 0;
    e_par    = 0;
  endtask

  function automatic int pick();
    if (m_lock) return m_lock_t;
    for (int i = 0; i < NS; i++) if (m_state[i] == 2) return i;
    return -1;
  endfunction

  function automatic bit exp_ok(input int t);
    return (m_rc[t] == 8'h00) && m_h[t][0] && m_h[t][1] && !m_perr[t];
  endfunction

  function automatic logic [0:511] rand_half();
    logic [0:511] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic idle();
    bus.alloc_valid = 0; bus.alloc_tag = 0;
    bus.ha_bwvalid = 0; bus.ha_bwtag = 0; bus.ha_bwtagpar = 0; bus.ha_bwad = 0;
    bus.ha_bwdata = '0; bus.ha_bwpar = 0;
    bus.ha_rvalid = 0; bus.ha_rtag = 0; bus.ha_rtagpar = 0; bus.ha_response = 0;
  endtask

  task automatic drive_alloc(input logic [7:0] tag);
    bus.alloc_valid = 1;
    bus.alloc_tag   = tag;
  endtask

  task automatic drive_bw(input logic [7:0] tag, input logic [5:0] ad, input logic [0:511] d,
                          input bit bad_dpar, input bit bad_tpar);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = ~^d[64*i +: 64];
    if (bad_dpar) p[5] = ~p[5];
    bus.ha_bwvalid  = 1;
    bus.ha_bwtag    = tag;
    bus.ha_bwtagpar = (~^tag) ^ bad_tpar;
    bus.ha_bwad     = ad;
    bus.ha_bwdata   = d;
    bus.ha_bwpar    = p;
  endtask

  task automatic drive_rv(input logic [7:0] tag, input logic [7:0] code, input bit bad_tpar);
    bus.ha_rvalid   = 1;
    bus.ha_rtag     = tag;
    bus.ha_rtagpar  = (~^tag) ^ bad_tpar;
    bus.ha_response = code;
  endtask

  // Checks current outputs at the falling edge, advances the model across the rising edge.
  task automatic step();
    int p, t;
    int s [NS];
    bit nt, np;
    logic [0:511] d;
    @(negedge clock);
    p = pick();
    check("line_valid", bus.line_valid, p >= 0);
    if (p >= 0) begin
      check("line_tag", bus.line_tag, p[7:0]);
      check("line_ok", bus.line_ok, exp_ok(p));
      if (m_h[p][0] && m_h[p][1]) check("line_data", bus.line_data, {m_d[p][0], m_d[p][1]});
    end else begin
      check("idle_tag", bus.line_tag, 8'd0);
      check("idle_ok", bus.line_ok, 1'b0);
      check("idle_data", bus.line_data, 1024'd0);
    end
    check("err_tag", bus.err_tag, e_tag);
    check("err_parity", bus.err_parity, e_par);
    if (reset) begin
      model_clear();
    end else begin
      nt = 0; np = 0;
      for (int i = 0; i < NS; i++) s[i] = m_state[i];
      if (bus.alloc_valid) begin
        t = int'(bus.alloc_tag);
        if (t < NS && s[t] == 0) begin
          m_state[t] = 1; m_h[t][0] = 0; m_h[t][1] = 0; m_perr[t] = 0; m_rc[t] = 8'h00;
        end else nt = 1;
      end
      if (bus.ha_bwvalid) begin
        t = int'(bus.ha_bwtag);
        if (bus.ha_bwtagpar != ~^bus.ha_bwtag) np = 1;
        else if (t < NS && bus.ha_bwad < 2 && s[t] == 1) begin
          d = bus.ha_bwdata;
          m_d[t][bus.ha_bwad[0]] = d;
          m_h[t][bus.ha_bwad[0]] = 1;
          for (int i = 0; i < 8; i++)
            if (bus.ha_bwpar[i] != ~^d[64*i +: 64]) begin np = 1; m_perr[t] = 1; end
        end else nt = 1;
      end
      if (bus.ha_rvalid) begin
        t = int'(bus.ha_rtag);
        if (bus.ha_rtagpar != ~^bus.ha_rtag) np = 1;
        else if (t < NS && s[t] == 1) begin
          m_state[t] = 2; m_rc[t] = bus.ha_response;
        end else nt = 1;
      end
      if (p >= 0) begin
        if (bus.line_ready) begin
          $display("xfer tag=%0d ok=%0d", p, exp_ok(p));
          m_state[p] = 0;
          m_lock = 0;
        end else begin
          m_lock = 1;
          m_lock_t = p;
        end
      end
      e_tag = nt;
      e_par = np;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [0:511] h0, h1;
    vecs[0] = '{0, 8'd0,   0, 8'd0, 0, 6'd0, 1, 8'd9, 0, 1, 0};  // rvalid foreign tag
    vecs[1] = '{1, 8'd0,   0, 8'd0, 0, 6'd0, 0, 8'd0, 0, 1, 0};  // alloc on pending slot
    vecs[2] = '{0, 8'd0,   1, 8'd0, 0, 6'd2, 0, 8'd0, 0, 1, 0};  // ha_bwad = 2
    vecs[3] = '{0, 8'd0,   1, 8'd0, 1, 6'd0, 0, 8'd0, 0, 0, 1};  // bad bw tag parity
    vecs[4] = '{0, 8'd0,   0, 8'd0, 0, 6'd0, 1, 8'd1, 1, 0, 1};  // bad r tag parity
    vecs[5] = '{0, 8'd0,   1, 8'd2, 0, 6'd1, 0, 8'd0, 0, 1, 0};  // bw on free slot
    vecs[6] = '{1, 8'd200, 0, 8'd0, 0, 6'd0, 0, 8'd0, 0, 1, 0};  // alloc foreign tag
    vecs[7] = '{0, 8'd0,   0, 8'd0, 0, 6'd0, 1, 8'd3, 0, 1, 0};  // rvalid on free slot

    idle();
    bus.line_ready = 1;
    reset = 1;
    repeat (3) @(posedge clock);
    #1;
    model_clear();
    step();
    reset = 0;
    check("rst_valid", bus.line_valid, 1'b0);
    check("rst_tag", bus.line_tag, 8'd0);
    check("rst_data", bus.line_data, 1024'd0);
    check("rst_ok", bus.line_ok, 1'b0);
    check("rst_errs", {bus.err_tag, bus.err_parity}, 2'b00);

    // Basic line assembly
    h0 = rand_half(); h1 = rand_half();
    idle(); drive_alloc(8'd0); step();
    idle(); drive_bw(8'd0, 6'd0, h0, 0, 0); step();
    idle(); drive_bw(8'd0, 6'd1, h1, 0, 0); step();
    idle(); drive_rv(8'd0, 8'h00, 0); step();
    check("s1_valid", bus.line_valid, 1'b1);
    check("s1_tag", bus.line_tag, 8'd0);
    check("s1_ok", bus.line_ok, 1'b1);
    check("s1_data", bus.line_data, {h0, h1});
    idle(); step();
    $display("seq basic done");

    // Lock: slot 2 presented first, slot 1 becomes ready but 2 stays held
    idle(); drive_alloc(8'd1); step();
    idle(); drive_alloc(8'd2); step();
    bus.line_ready = 0;
    idle(); drive_rv(8'd2, 8'h00, 0); step();
    idle(); drive_rv(8'd1, 8'h00, 0); step();
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      check("lock_tag", bus.line_tag, 8'd2);
    end
    bus.line_ready = 1;
    step();
    check("lock_next_tag", bus.line_tag, 8'd1);
    step();
    check("lock_drained", bus.line_valid, 1'b0);
    $display("seq lock done");

    // Buffer write and response in the same cycle
    h0 = rand_half(); h1 = rand_half();
    idle(); drive_alloc(8'd3); step();
    idle(); drive_bw(8'd3, 6'd0, h0, 0, 0); step();
    idle(); drive_bw(8'd3, 6'd1, h1, 0, 0); drive_rv(8'd3, 8'h00, 0); step();
    check("same_ok", bus.line_ok, 1'b1);
    check("same_data", bus.line_data, {h0, h1});
    idle(); step();
    $display("seq same-cycle done");

    // Data parity error, then a dropped response with bad tag parity
    idle(); drive_alloc(8'd0); step();
    idle(); drive_bw(8'd0, 6'd0, rand_half(), 1, 0); step();
    check("dpar_pulse", bus.err_parity, 1'b1);
    idle(); drive_bw(8'd0, 6'd1, rand_half(), 0, 0); step();
    check("dpar_pulse_end", bus.err_parity, 1'b0);
    idle(); drive_rv(8'd0, 8'h00, 0); step();
    check("dpar_line_ok", bus.line_ok, 1'b0);
    idle(); drive_alloc(8'd1); step();
    idle(); drive_rv(8'd1, 8'h00, 1); step();
    check("rtagpar_pulse", bus.err_parity, 1'b1);
    check("rtagpar_no_line", bus.line_valid, 1'b0);
    idle(); drive_rv(8'd1, 8'h00, 0); step();
    idle(); step();
    $display("seq parity done");

    // Error vectors with slots 0 and 1 pending
    idle(); drive_alloc(8'd0); step();
    idle(); drive_alloc(8'd1); step();
    for (int i = 0; i < 8; i++) begin
      idle();
      if (vecs[i].av) drive_alloc(vecs[i].at);
      if (vecs[i].bv) drive_bw(vecs[i].bt, vecs[i].bad, rand_half(), 0, vecs[i].btp_bad);
      if (vecs[i].rv) drive_rv(vecs[i].rt, 8'h00, vecs[i].rtp_bad);
      step();
      check($sformatf("vec%0d_err_tag", i), bus.err_tag, vecs[i].exp_tag);
      check($sformatf("vec%0d_err_parity", i), bus.err_parity, vecs[i].exp_par);
      check($sformatf("vec%0d_no_line", i), bus.line_valid, 1'b0);
      $display("vec %0d err_tag=%0d err_parity=%0d", i, bus.err_tag, bus.err_parity);
    end
    idle(); drive_rv(8'd0, 8'h01, 0); step();
    check("nondone_valid", bus.line_valid, 1'b1);
    check("nondone_ok", bus.line_ok, 1'b0);
    idle(); step();

    // Reset with slots 1 and 2 pending
    idle(); drive_alloc(8'd2); step();
    idle(); reset = 1; step();
    reset = 0;
    check("rst_mid_valid", bus.line_valid, 1'b0);
    idle(); drive_rv(8'd1, 8'h00, 0); step();
    check("rst_mid_err1", bus.err_tag, 1'b1);
    idle(); drive_rv(8'd2, 8'h00, 0); step();
    check("rst_mid_err2", bus.err_tag, 1'b1);
    check("rst_mid_no_line", bus.line_valid, 1'b0);
    idle(); step();
    $display("seq reset done");

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) < 3) drive_alloc(8'($urandom_range(0, 5)));
      if ($urandom_range(0, 9) < 4)
        drive_bw(8'($urandom_range(0, 5)),
                 ($urandom_range(0, 19) == 0) ? 6'd2 : 6'($urandom_range(0, 1)),
                 rand_half(), $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) < 2)
        drive_rv(8'($urandom_range(0, 5)),
                 ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                 $urandom_range(0, 29) == 0);
      bus.line_ready = ($urandom_range(0, 9) < 6);
      step();
    end
    reset = 0;
    bus.line_ready = 1;
    idle();
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
